// File: rtl/board_input_cond_pkg.sv
// ============================================================================
// Module   : board_input_cond_pkg
// Purpose  : Board input defaults and width helpers for the input conditioner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package board_input_cond_pkg;

  localparam int c_SW_NUM       = 10;
  localparam int c_BTN_NUM      = 2;
  localparam int c_DEB_TICK_DIV = 50000;
  localparam int c_DEB_STABLE   = 10;
  localparam int c_BTN_STOP     = 0;
  localparam int c_BTN_DEBUG    = 1;

  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks) + 1;
  endfunction

  // A divide-by-one prescaler still needs a legal (1-bit) vector width.
  function automatic int div_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_input_cond_debounce_bit.sv
// ============================================================================
// Module   : board_input_cond_debounce_bit
// Purpose  : One input bit: 2-flop synchronizer plus tick-based debounce.
// Revision : 1.0
// ============================================================================
`default_nettype none

module board_input_cond_debounce_bit
  import board_input_cond_pkg::*;
#(
  parameter int STABLE_TICKS = c_DEB_STABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CW         = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]   c_CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_accept;

  // Any sample matching the stable level discards the partial count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == c_CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        w_accept = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = w_accept & sync2_q;
  assign fall_o  = w_accept & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/board_input_cond.sv
// ============================================================================
// Module   : board_input_cond
// Purpose  : Synchronize/debounce board switches and buttons; edge pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module board_input_cond
  import board_input_cond_pkg::*;
#(
  parameter int N_SW         = c_SW_NUM,
  parameter int N_BTN        = c_BTN_NUM,
  parameter int TICK_DIV     = c_DEB_TICK_DIV,
  parameter int STABLE_TICKS = c_DEB_STABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_SW-1:0]  sw_out,
  output logic             sw_changed,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic             w_tick;
  logic [N_SW-1:0]  w_sw_rise;
  logic [N_SW-1:0]  w_sw_fall;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] w_btn_fall;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic             changed_q;

  generate
    if (TICK_DIV == 1) begin : g_tick_every
      assign w_tick = 1'b1;
    end else begin : g_presc
      localparam int            PW          = div_width(TICK_DIV);
      localparam logic [PW-1:0] c_PRESC_TOP = PW'(TICK_DIV - 1);
      logic [PW-1:0] presc_q;
      logic [PW-1:0] presc_d;

      assign w_tick  = (presc_q == c_PRESC_TOP);
      assign presc_d = w_tick ? '0 : presc_q + PW'(1);

      always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
      end
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
      board_input_cond_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (w_tick),
        .raw_i   (sw_raw[i]),
        .level_o (sw_out[i]),
        .rise_o  (w_sw_rise[i]),
        .fall_o  (w_sw_fall[i])
      );
    end
    for (genvar j = 0; j < N_BTN; j++) begin : g_btn
      board_input_cond_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (w_tick),
        .raw_i   (btn_raw[j]),
        .level_o (btn_level[j]),
        .rise_o  (w_btn_rise[j]),
        .fall_o  (w_btn_fall[j])
      );
    end
  endgenerate

  // Pulses register on the same edge that commits the new stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
      changed_q <= 1'b0;
    end else begin
      press_q   <= w_btn_rise;
      release_q <= w_btn_fall;
      changed_q <= |(w_sw_rise | w_sw_fall);
    end
  end

  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign sw_changed  = changed_q;

endmodule

`default_nettype wire

// File: doc/board_input_cond.md
Name: board_input_cond

Overview:
- Input-side conditioner for the FPGA board top level; the counterpart of the 7-segment/LED output path.
- Takes raw asynchronous slide switches and push buttons (stop, Debug_DM) and synchronizes and debounces them.
- Provides clean levels for the CPU's switch_in/stop/Debug_DM inputs, plus one-cycle press/release/change pulses for single-step and debug control.
- Sits between board pins and CPU in the clk_cpu domain.

Parameters:
- N_SW, 10, number of slide switches.
- N_BTN, 2, number of push buttons (bit 0 = stop, bit 1 = Debug_DM).
- TICK_DIV, 50000, clock cycles per debounce sample tick; must be >= 1.
- STABLE_TICKS, 10, consecutive differing ticks required to accept a new level; must be >= 1.

Ports:
- clk  in  1  system clock (clk_cpu domain)
- rst  in  1  synchronous, active-high reset
- sw_raw  in  N_SW  raw asynchronous switch pins
- btn_raw  in  N_BTN  raw asynchronous button pins
- sw_out  out  N_SW  debounced switch levels
- sw_changed  out  1  one-cycle pulse when any sw_out bit changes
- btn_level  out  N_BTN  debounced button levels
- btn_press  out  N_BTN  one-cycle pulse on debounced 0->1
- btn_release  out  N_BTN  one-cycle pulse on debounced 1->0

Behaviour:
- One clock domain; rst is synchronous and active-high. All state updates on rising clk only.
- Reset clears everything to 0: all outputs, synchronizer flops, prescaler, per-bit counters.
- A reset asserted mid-debounce discards any partial count.
- Synchronizer: 2-flop chain per input bit. sync2 reflects raw 2 edges after the raw value is first sampled.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 in the cycle where count==TICK_DIV-1. TICK_DIV=1 gives tick every cycle.
- Per-bit debounce, evaluated every cycle (state: stable, cnt):
  - sync2==stable -> cnt<=0, regardless of tick.
  - sync2!=stable and tick and cnt==STABLE_TICKS-1 -> stable<=sync2, cnt<=0.
  - sync2!=stable and tick otherwise -> cnt<=cnt+1.
  - sync2!=stable and no tick -> hold.
- cnt width is clog2(STABLE_TICKS)+1. cnt never exceeds STABLE_TICKS-1.
- Glitch rejection: any return to the stable value before acceptance resets cnt to 0. Pulses shorter than STABLE_TICKS ticks never reach the outputs.
- Latency with TICK_DIV=1: sw_out/btn_level change on the (STABLE_TICKS+2)th edge after raw is first sampled. Example: STABLE_TICKS=4 gives 6 edges.
- Pulses are registered in the same edge that updates stable, so they are concurrent with the first cycle showing the new level, and last exactly 1 cycle:
  - btn_press[i]=1 when btn_level[i] goes 0->1.
  - btn_release[i]=1 when btn_level[i] goes 1->0.
  - sw_changed=1 if any sw_out bit changed on that edge.
- Simultaneous acceptance on several bits in one edge: all levels update and all corresponding pulses assert together. sw_changed is a single pulse.
- A raw input held at 1 through reset release is treated as a new event: it is accepted after full latency and produces btn_press/sw_changed.
- No pulse while a level is unchanged. Back-to-back accepted edges on one bit are at least STABLE_TICKS ticks apart.

Decomposition:
- def.vh holds the board defaults: `SW_NUM 10, `BTN_NUM 2, `DEB_TICK_DIV 50000, `DEB_STABLE 10, and the bit indices `BTN_STOP 0, `BTN_DEBUG 1.
- The top module owns the prescaler, the pulse logic and the sw_changed OR-reduction.
- One natural sub-module, debounce_bit: the per-bit 2-flop synchronizer plus stable/cnt register. It takes clk, rst, tick, raw and outputs level and rise/fall. It is instantiated N_SW+N_BTN times via generate.

Test Plan (TICK_DIV=1, STABLE_TICKS=4 unless noted):
- Reset, then btn_raw[0] 0->1 held -> btn_level[0]=1 on the 6th edge, btn_press[0]=1 for exactly that cycle, btn_release=0 throughout.
- sw_raw[3] high for 3 cycles then low -> sw_out stays 0x000, sw_changed never asserts.
- sw_raw 0x000->0x201 in the same cycle -> sw_out=0x201 on the 6th edge, single 1-cycle sw_changed pulse.
- btn_raw[1] held 1 then released after level=1 -> btn_release[1]=1 for one cycle, 6 edges after release, btn_level[1]=0.
- TICK_DIV=5: btn_raw[0] rises, aligned so its first tick is the earliest possible after the 2-flop sync -> level rises within 2+4*5 edges, and strictly after 2+3*5 edges; exactly one press pulse.
- Assert rst for 1 cycle while cnt=2 mid-debounce with raw still 1 -> all outputs 0 after reset edge; level re-rises a full 6 edges after reset deasserts, with one press pulse.
